// File: rtl/upuart_rx_if.sv
// upuart_rx_if: bundle of the UART receiver's line, strobe, FIFO and status
// signals.
//   master : the receiver. It drives data_out, data_wr, rts, frame_err and
//            overrun_err, and samples rxd, uclk_rx and fifo_full.
//   slave  : the surrounding logic (FIFO, baud generator, line, register
//            block), seen from the other side.
interface upuart_rx_if;
  logic [7:0] data_out;
  logic       data_wr;
  logic       fifo_full;
  logic       uclk_rx;
  logic       rxd;
  logic       rts;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    output data_out, data_wr, rts, frame_err, overrun_err,
    input  fifo_full, uclk_rx, rxd
  );

  modport slave (
    input  data_out, data_wr, rts, frame_err, overrun_err,
    output fifo_full, uclk_rx, rxd
  );
endinterface

// File: rtl/upuart_rx.sv
// upuart_rx: 8N1 UART receiver.
// rxd is oversampled OVS times per bit on the uclk_rx strobe and
// majority-filtered. Each good byte is written to the RX FIFO. RTS is driven
// from FIFO fullness. Framing and overrun errors are reported as one-cycle
// pulses.
// Ports:
//   clk  : system clock
//   nrst : asynchronous active-low reset
//   bus  : upuart_rx_if.master carrying the following signals:
//     data_out    : received byte
//     data_wr     : one-cycle FIFO write strobe
//     fifo_full   : FIFO full, sampled at mid stop bit
//     uclk_rx     : oversample strobe
//     rxd         : asynchronous serial line
//     rts         : registered copy of fifo_full, 1 = hold off
//     frame_err   : one-cycle pulse for a low stop bit
//     overrun_err : one-cycle pulse for a good frame dropped on full FIFO
module upuart_rx #(
  parameter int OVS = 16,
  parameter int CW  = 5
) (
  input  logic         clk,
  input  logic         nrst,
  upuart_rx_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic          sync_p0, sync_p1;
  logic [2:0]    vote;
  logic          rx_v;
  logic          rts_q;

  state_t        state, state_n;
  logic [CW-1:0] tick, tick_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_q, data_n;
  logic          wr_q, wr_n;
  logic          fe_q, fe_n;
  logic          ov_q, ov_n;

  assign rx_v = maj3(vote);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      vote    <= 3'b111;
      rts_q   <= 1'b1;
      state   <= S_IDLE;
      tick    <= '0;
      bitc    <= '0;
      shift   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      // stage p0/p1: metastability synchronizer on the raw line
      sync_p0 <= bus.rxd;
      sync_p1 <= sync_p0;
      // vote window advances only on oversample strobes
      if (bus.uclk_rx) begin
        vote <= {vote[1:0], sync_p1};
      end
      rts_q  <= bus.fifo_full;
      state  <= state_n;
      tick   <= tick_n;
      bitc   <= bitc_n;
      shift  <= shift_n;
      data_q <= data_n;
      wr_q   <= wr_n;
      fe_q   <= fe_n;
      ov_q   <= ov_n;
    end
  end

  // Counter compares use the value before increment, so START samples at
  // OVS/2 strobes after the edge and each later bit OVS strobes after that.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitc_n  = bitc;
    shift_n = shift;
    data_n  = data_q;
    wr_n    = 1'b0;
    fe_n    = 1'b0;
    ov_n    = 1'b0;
    if (bus.uclk_rx) begin
      case (state)
        S_IDLE: begin
          if (!rx_v) begin
            state_n = S_START;
            tick_n  = '0;
          end
        end
        S_START: begin
          if (tick == HALF_M1) begin
            tick_n  = '0;
            bitc_n  = '0;
            // a line that is high again at mid start bit was a glitch
            state_n = rx_v ? S_IDLE : S_DATA;
          end else begin
            tick_n = tick + CW'(1);
          end
        end
        S_DATA: begin
          if (tick == FULL_M1) begin
            shift_n = {rx_v, shift[7:1]};
            tick_n  = '0;
            bitc_n  = bitc + 3'd1;
            if (bitc == 3'd7) begin
              state_n = S_STOP;
            end
          end else begin
            tick_n = tick + CW'(1);
          end
        end
        S_STOP: begin
          if (tick == FULL_M1) begin
            // leaving at mid stop bit leaves half a bit to catch the next start edge
            tick_n = '0;
            if (!rx_v) begin
              fe_n    = 1'b1;
              state_n = S_BRK;
            end else if (bus.fifo_full) begin
              ov_n    = 1'b1;
              state_n = S_IDLE;
            end else begin
              data_n  = shift;
              wr_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            tick_n = tick + CW'(1);
          end
        end
        S_BRK: begin
          // a held-low line must go high before another start is accepted
          if (rx_v) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_wr     = wr_q;
  assign bus.rts         = rts_q;
  assign bus.frame_err   = fe_q;
  assign bus.overrun_err = ov_q;

endmodule

// File: doc/upuart_rx.md
Name: upuart_rx

Overview:
- UART receiver, the counterpart of the TX path in the upuart block.
- Oversamples `rxd` on the `uclk_rx` strobe and majority-filters the line.
- Frames 8N1 characters (start, 8 data bits LSB first, 1 stop) and pushes each good byte into the RX FIFO.
- Drives RTS flow control from FIFO fullness and reports framing and overrun errors to the register block as single-cycle pulses.

Parameters:
- OVS, 16, `uclk_rx` ticks per bit period; even, minimum 8.
- CW, 5, tick counter width; must satisfy 2^CW > OVS.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- data_out  output  8  received byte to RX FIFO
- data_wr  output  1  FIFO write strobe, one `clk` cycle
- fifo_full  input  1  RX FIFO full
- uclk_rx  input  1  oversample strobe, one `clk` cycle wide, OVS × baud, free-running
- rxd  input  1  UART RX line, asynchronous
- rts  output  1  flow control; 0 = ready to receive, 1 = hold off
- frame_err  output  1  stop bit sampled low, one-cycle pulse
- overrun_err  output  1  good frame dropped because FIFO full, one-cycle pulse

Behaviour:
- Clocking/reset: one clock `clk`; reset `nrst` asynchronous, active-low. All state changes on posedge `clk`, qualified by `uclk_rx` unless stated otherwise.
- Reset values:
  - data_out = 8'h00; data_wr, frame_err, overrun_err = 0; rts = 1.
  - Synchronizer = 2'b11; vote register = 3'b111.
  - FSM = IDLE; tick counter = 0; bit counter = 0; shift register = 0.
- Input conditioning:
  - 2-flop synchronizer on `rxd`, every `clk`.
  - On each `uclk_rx`, synchronized value shifts into a 3-bit register; `rx_v` = majority of 3 bits.
- rts: registered copy of `fifo_full` every `clk`; follows one cycle after reset release.
- FSM (evaluated only on `uclk_rx` cycles):
  - IDLE: `rx_v` = 0 → START, tick counter = 0.
  - START: increment tick counter. When tick = OVS/2−1 (mid start bit):
    - `rx_v` = 0 → DATA, tick = 0, bit counter = 0.
    - `rx_v` = 1 → IDLE (glitch rejected, no output).
  - DATA: increment tick counter. When tick = OVS−1:
    - shift register = {`rx_v`, shift[7:1]}; tick = 0; bit counter +1.
    - After bit 7 → STOP.
  - STOP: when tick = OVS−1, sample `rx_v` (mid stop bit):
    - `rx_v` = 1 and `fifo_full` = 0 → data_out = shift register, data_wr = 1; → IDLE.
    - `rx_v` = 1 and `fifo_full` = 1 → overrun_err = 1, data_out unchanged; → IDLE.
    - `rx_v` = 0 → frame_err = 1, no write; → BREAK.
  - BREAK: wait for `rx_v` = 1 → IDLE. A held-low line (break) yields exactly one frame_err.
- Timing:
  - data_wr / frame_err / overrun_err assert in the `clk` cycle after the mid-stop-bit `uclk_rx` tick and deassert the next `clk`.
  - Exactly one of the three pulses per completed frame.
- Resync: returning to IDLE at mid stop bit allows a start bit to be detected immediately; back-to-back frames must be received with no gap.
- `fifo_full` is sampled only at the mid-stop tick; changes during the frame have no effect.
- `nrst` asserted mid-frame: immediate return to the reset values; the partial byte is lost and no pulse is issued.

Test Plan:
- OVS=16, send 0xA5 at nominal baud, `fifo_full`=0 → single data_wr pulse with data_out=8'hA5, ~152 `uclk_rx` ticks after start edge; no error pulses.
- `rxd` low for 4 ticks then high → FSM back to IDLE; no data_wr, frame_err or overrun_err.
- Send 0x3C with stop bit forced 0, then line held low 30 bit times → exactly one frame_err, no data_wr. After line returns high, 0x81 is received correctly.
- `fifo_full`=1 throughout a 0x55 frame → rts=1, overrun_err pulse, no data_wr, data_out keeps previous value. Deassert `fifo_full`, send 0x66 → data_wr with 8'h66, rts=0.
- Back-to-back 0x00, 0xFF, 0x7E with zero idle time; also ±3% baud skew → three data_wr pulses in order with correct values.
- Assert `nrst` after the 4th data bit of a frame → all outputs at reset values. Next frame 0x12 after release → received correctly.
